// File: rtl/game_sequencer_pkg.sv
// Shared state encoding and score width for the Flappy Bird datapath.
// Physics and display blocks decode game_state against these values.
package game_sequencer_pkg;

    localparam int SCORE_W = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its environment.
// master = buttons/VGA/collision side, slave = the sequencer.
interface game_sequencer_if #(
    parameter int SCORE_W = game_sequencer_pkg::SCORE_W
);
    logic               frame_tick;
    logic               flap_btn;
    logic               collision;
    logic [SCORE_W-1:0] score;
    logic               reset_physics;
    logic               move_en;
    logic               flap_pulse;
    logic [1:0]         game_state;
    logic [2:0]         speed;
    logic [SCORE_W-1:0] high_score;

    modport master (
        output frame_tick, flap_btn, collision, score,
        input  reset_physics, move_en, flap_pulse,
        input  game_state, speed, high_score
    );

    modport slave (
        input  frame_tick, flap_btn, collision, score,
        output reset_physics, move_en, flap_pulse,
        output game_state, speed, high_score
    );
endinterface

// File: rtl/game_sequencer_move_burst_gen.sv
// Emits n back-to-back move strobes after a load.
// kill clears the burst and masks the strobe in the same cycle.
module move_burst_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       kill,
    input  logic [2:0] n,
    output logic       move_en
);
    logic [2:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (kill) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= n;
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign move_en = (cnt_q != 3'd0) && !kill;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: idle/playing/dying/game-over sequencing,
// per-frame move bursts, flap pulses and session high score.
module game_sequencer #(
    parameter int SCORE_W        = 7,
    parameter int DEATH_FRAMES   = 60,
    parameter int LOCKOUT_FRAMES = 30,
    parameter int SPEED_SHIFT    = 4,
    parameter int MAX_SPEED      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    game_sequencer_if.slave   gif
);
    import game_sequencer_pkg::*;

    state_t             state_q, state_d;
    logic               flap_q;
    logic               fl_edge;
    logic [7:0]         fcnt_q;
    logic [2:0]         speed_q;
    logic [SCORE_W-1:0] high_q;
    logic               rp_q, rp_d;
    logic               fp_q, fp_d;
    logic               load, kill;
    logic               death_done, lock_done;
    logic [SCORE_W:0]   spd_raw;
    logic [2:0]         spd;

    assign fl_edge = gif.flap_btn && !flap_q;

    assign spd_raw = {1'b0, gif.score >> SPEED_SHIFT}
                   + (SCORE_W+1)'(1);
    assign spd = (spd_raw > (SCORE_W+1)'(MAX_SPEED))
               ? 3'(MAX_SPEED) : spd_raw[2:0];

    // the tick that brings the count to DEATH_FRAMES ends DYING
    assign death_done = gif.frame_tick
                     && (fcnt_q >= 8'(DEATH_FRAMES - 1));
    assign lock_done  = (fcnt_q >= 8'(LOCKOUT_FRAMES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            flap_q  <= 1'b0;
            fcnt_q  <= '0;
            speed_q <= 3'd1;
            high_q  <= '0;
            rp_q    <= 1'b1;
            fp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flap_q  <= gif.flap_btn;
            rp_q    <= rp_d;
            fp_q    <= fp_d;
            if (state_d != state_q) begin
                fcnt_q <= '0;
            end else if (gif.frame_tick && fcnt_q != 8'hFF) begin
                fcnt_q <= fcnt_q + 8'd1;
            end
            if (load) begin
                speed_q <= spd;
            end
            if (state_q == PLAYING && gif.collision
                && gif.score > high_q) begin
                high_q <= gif.score;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (fl_edge) state_d = PLAYING;
            PLAYING:   if (gif.collision) state_d = DYING;
            DYING:     if (death_done) state_d = GAME_OVER;
            GAME_OVER: if (fl_edge && lock_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        kill = 1'b1;
        fp_d = 1'b0;
        rp_d = (state_d == IDLE);
        unique case (1'b1)
            (state_q == IDLE): begin
                fp_d = fl_edge;
            end
            (state_q == PLAYING && !gif.collision): begin
                kill = 1'b0;
                load = gif.frame_tick;
                fp_d = fl_edge;
            end
            default: ;
        endcase
    end

    move_burst_gen u_burst (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .kill    (kill),
        .n       (spd),
        .move_en (gif.move_en)
    );

    assign gif.reset_physics = rp_q;
    assign gif.flap_pulse    = fp_q;
    assign gif.game_state    = state_q;
    assign gif.speed         = speed_q;
    assign gif.high_score    = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized bench for game_sequencer.
// Expected values come from the game rules computed inline.
module tb_game_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   hs_model;

    game_sequencer_if #(.SCORE_W(7)) gif ();

    game_sequencer #(
        .SCORE_W        (7),
        .DEATH_FRAMES   (60),
        .LOCKOUT_FRAMES (30),
        .SPEED_SHIFT    (4),
        .MAX_SPEED      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gif   (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_speed(input int s);
        int v;
        v = 1 + s / 16;
        return (v > 4) ? 4 : v;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        gif.flap_btn = 1'b1;
        cyc();
        gif.flap_btn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            gif.frame_tick = 1'b1;
            cyc();
            gif.frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic burst(input int s, input string tag);
        logic [31:0] mask;
        int          sp;
        sp = exp_speed(s);
        gif.score = 7'(s);
        cyc();
        gif.frame_tick = 1'b1;
        cyc();
        gif.frame_tick = 1'b0;
        chk({tag, "_speed"}, 32'(gif.speed), 32'(sp));
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = gif.move_en;
            cyc();
        end
        chk({tag, "_mask"}, mask, (32'd1 << sp) - 32'd1);
    endtask

    task automatic end_game(input int s, input string tag);
        gif.score = 7'(s);
        gif.collision = 1'b1;
        cyc();
        gif.collision = 1'b0;
        if (s > hs_model) hs_model = s;
        chk({tag, "_state"}, 32'(gif.game_state), 32'd2);
        chk({tag, "_high"}, 32'(gif.high_score), 32'(hs_model));
    endtask

    task automatic back_to_idle(input string tag);
        ticks(60);
        ticks(30);
        press();
        chk({tag, "_idle"}, 32'(gif.game_state), 32'd0);
        cyc();
    endtask

    initial begin
        logic [31:0] mask;
        int          s;
        checks         = 0;
        failures       = 0;
        hs_model       = 0;
        rst_n          = 1'b0;
        gif.frame_tick = 1'b0;
        gif.flap_btn   = 1'b0;
        gif.collision  = 1'b0;
        gif.score      = '0;
        repeat (3) cyc();
        chk("rst_state", 32'(gif.game_state), 32'd0);
        chk("rst_rphys", 32'(gif.reset_physics), 32'd1);
        chk("rst_move", 32'(gif.move_en), 32'd0);
        chk("rst_flap", 32'(gif.flap_pulse), 32'd0);
        chk("rst_speed", 32'(gif.speed), 32'd1);
        chk("rst_high", 32'(gif.high_score), 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc();

        gif.flap_btn = 1'b1;
        chk("pre_start", 32'(gif.game_state), 32'd0);
        cyc();
        gif.flap_btn = 1'b0;
        chk("start_state", 32'(gif.game_state), 32'd1);
        chk("start_rphys", 32'(gif.reset_physics), 32'd0);
        chk("start_flap", 32'(gif.flap_pulse), 32'd1);
        cyc();
        chk("start_flap_off", 32'(gif.flap_pulse), 32'd0);

        burst(0, "s0");
        burst(35, "s35");
        burst(100, "s100");
        for (int k = 0; k < 4; k++) begin
            burst(int'($urandom_range(0, 127)), "srnd");
        end

        press();
        chk("play_flap", 32'(gif.flap_pulse), 32'd1);
        cyc();
        chk("play_flap_off", 32'(gif.flap_pulse), 32'd0);

        // retick after the first strobe of a 3-strobe burst
        gif.score = 7'd35;
        gif.frame_tick = 1'b1;
        cyc();
        gif.frame_tick = 1'b0;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = gif.move_en;
            gif.frame_tick = (i == 0);
            cyc();
        end
        gif.frame_tick = 1'b0;
        chk("reload_mask", mask, 32'hF);

        gif.score = 7'd12;
        gif.frame_tick = 1'b1;
        cyc();
        gif.frame_tick = 1'b0;
        chk("pre_hit_move", 32'(gif.move_en), 32'd1);
        gif.collision  = 1'b1;
        gif.frame_tick = 1'b1;
        gif.flap_btn   = 1'b1;
        #1;
        chk("hit_move_now", 32'(gif.move_en), 32'd0);
        cyc();
        gif.collision  = 1'b0;
        gif.frame_tick = 1'b0;
        gif.flap_btn   = 1'b0;
        hs_model = 12;
        chk("hit_state", 32'(gif.game_state), 32'd2);
        chk("hit_flap", 32'(gif.flap_pulse), 32'd0);
        chk("hit_high", 32'(gif.high_score), 32'd12);
        chk("hit_rphys", 32'(gif.reset_physics), 32'd0);
        mask = '0;
        for (int i = 0; i < 6; i++) begin
            mask[i] = gif.move_en;
            cyc();
        end
        chk("dying_frozen", mask, 32'd0);

        ticks(59);
        chk("dying_59", 32'(gif.game_state), 32'd2);
        ticks(1);
        chk("dying_60", 32'(gif.game_state), 32'd3);

        ticks(10);
        press();
        chk("lockout_ign", 32'(gif.game_state), 32'd3);
        cyc();
        ticks(20);
        press();
        chk("over_idle", 32'(gif.game_state), 32'd0);
        chk("over_rphys", 32'(gif.reset_physics), 32'd1);
        cyc();
        press();
        chk("restart", 32'(gif.game_state), 32'd1);
        cyc();

        end_game(9, "g9");
        back_to_idle("g9");

        for (int g = 0; g < 3; g++) begin
            press();
            cyc();
            s = int'($urandom_range(0, 127));
            burst(s, "grnd");
            end_game(s, "grnd");
            back_to_idle("grnd");
        end

        press();
        cyc();
        gif.score = 7'd100;
        gif.frame_tick = 1'b1;
        cyc();
        gif.frame_tick = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_move", 32'(gif.move_en), 32'd0);
        chk("arst_state", 32'(gif.game_state), 32'd0);
        chk("arst_high", 32'(gif.high_score), 32'd0);
        chk("arst_rphys", 32'(gif.reset_physics), 32'd1);
        cyc();
        rst_n = 1'b1;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = gif.move_en;
            cyc();
        end
        chk("arst_nomore", mask, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
